// File: rtl/match_controller_if.sv
// match_controller_if
//   Bundles the sequencer's game-side signals.
//   master: the match_controller (drives phase and results, reads start/health).
//   slave : the game top level / status datapath (drives start/health).
//   start          - level, begins a match from IDLE or MATCH_OVER
//   player*_health - remaining health per player (3 bits)
//   round_rst      - synchronous reset to the health/block counters
//   freeze         - 1 = player state machines ignore inputs
//   phase          - IDLE=0 CLEAR=1 INTRO=2 FIGHT=3 KO=4 MATCH_OVER=5
//   p1_wins/p2_wins, round_winner, match_winner - match results
interface match_controller_if;
    logic       start;
    logic [2:0] player1_health;
    logic [2:0] player2_health;
    logic       round_rst;
    logic       freeze;
    logic [2:0] phase;
    logic [1:0] p1_wins;
    logic [1:0] p2_wins;
    logic [1:0] round_winner;
    logic [1:0] match_winner;

    modport master (
        input  start, player1_health, player2_health,
        output round_rst, freeze, phase, p1_wins, p2_wins, round_winner, match_winner
    );

    modport slave (
        output start, player1_health, player2_health,
        input  round_rst, freeze, phase, p1_wins, p2_wins, round_winner, match_winner
    );
endinterface

// File: rtl/match_controller.sv
// match_controller
//   Round/match sequencer for the two-player fighter. Moore FSM whose
//   round_rst/freeze/phase decode straight from the state register; the
//   phase timer, win tallies and winner flags are registered alongside.
//   Ports:
//     clk - system clock (rising edge)
//     rst - synchronous active-high reset
//     bus - match_controller_if.master (start, health in; phase/results out)
module match_controller #(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int INTRO_CYCLES  = 120,
    parameter int KO_CYCLES     = 90,
    parameter int TW            = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    match_controller_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        INTRO      = 3'd2,
        FIGHT      = 3'd3,
        KO         = 3'd4,
        MATCH_OVER = 3'd5
    } state_t;

    localparam logic [TW-1:0] INTRO_LOAD = TW'(INTRO_CYCLES - 1);
    localparam logic [TW-1:0] KO_LOAD    = TW'(KO_CYCLES - 1);
    localparam logic [1:0]    WIN_CNT    = 2'(ROUNDS_TO_WIN);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [1:0]    p1_wins, p1_wins_n;
    logic [1:0]    p2_wins, p2_wins_n;
    logic [1:0]    round_winner, round_winner_n;
    logic [1:0]    match_winner, match_winner_n;

    // Values >= 4 are the datapath's 3-count underflow wrap (e.g. 7),
    // so they count as depleted just like 0.
    logic p1_dep, p2_dep;
    assign p1_dep = (bus.player1_health == 3'd0) | bus.player1_health[2];
    assign p2_dep = (bus.player2_health == 3'd0) | bus.player2_health[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            p1_wins      <= 2'd0;
            p2_wins      <= 2'd0;
            round_winner <= 2'b00;
            match_winner <= 2'b00;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            p1_wins      <= p1_wins_n;
            p2_wins      <= p2_wins_n;
            round_winner <= round_winner_n;
            match_winner <= match_winner_n;
        end
    end

    always_comb begin
        state_n        = state;
        timer_n        = timer;
        p1_wins_n      = p1_wins;
        p2_wins_n      = p2_wins;
        round_winner_n = round_winner;
        match_winner_n = match_winner;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n        = CLEAR;
                    p1_wins_n      = 2'd0;
                    p2_wins_n      = 2'd0;
                    round_winner_n = 2'b00;
                    match_winner_n = 2'b00;
                end
            end
            CLEAR: begin
                state_n        = INTRO;
                timer_n        = INTRO_LOAD;
                round_winner_n = 2'b00;
            end
            INTRO: begin
                if (timer == '0) state_n = FIGHT;
                else             timer_n = timer - TW'(1);
            end
            FIGHT: begin
                if (p1_dep | p2_dep) begin
                    state_n = KO;
                    timer_n = KO_LOAD;
                    if (p1_dep && p2_dep) begin
                        round_winner_n = 2'b11;
                    end else if (p2_dep) begin
                        round_winner_n = 2'b01;
                        p1_wins_n      = p1_wins + 2'd1;
                    end else begin
                        round_winner_n = 2'b10;
                        p2_wins_n      = p2_wins + 2'd1;
                    end
                end
            end
            KO: begin
                if (timer != '0) begin
                    timer_n = timer - TW'(1);
                end else if (p1_wins == WIN_CNT) begin
                    state_n        = MATCH_OVER;
                    match_winner_n = 2'b01;
                end else if (p2_wins == WIN_CNT) begin
                    state_n        = MATCH_OVER;
                    match_winner_n = 2'b10;
                end else begin
                    state_n = CLEAR;
                end
            end
            MATCH_OVER: begin
                // round_winner is left alone here; CLEAR wipes it on exit.
                if (bus.start) begin
                    state_n        = CLEAR;
                    p1_wins_n      = 2'd0;
                    p2_wins_n      = 2'd0;
                    match_winner_n = 2'b00;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.round_rst    = (state == IDLE) || (state == CLEAR);
    assign bus.freeze       = (state != FIGHT);
    assign bus.phase        = state;
    assign bus.p1_wins      = p1_wins;
    assign bus.p2_wins      = p2_wins;
    assign bus.round_winner = round_winner;
    assign bus.match_winner = match_winner;

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller
//   Directed table of one-cycle vectors walking through a full match, plus
//   hand-written sequences for reset mid-round, start held in FIGHT/KO, and
//   depletion on the first FIGHT cycle. Short timers (INTRO=3, KO=2).
module tb_match_controller;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    match_controller_if bus ();

    match_controller #(
        .ROUNDS_TO_WIN (2),
        .INTRO_CYCLES  (3),
        .KO_CYCLES     (2),
        .TW            (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic [2:0] h1;
        logic [2:0] h2;
        logic [2:0] ph;
        logic       rr;
        logic       fz;
        logic [1:0] p1w;
        logic [1:0] p2w;
        logic [1:0] rw;
        logic [1:0] mw;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic [2:0] h1, logic [2:0] h2,
                                logic [2:0] ph, logic rr, logic fz,
                                logic [1:0] p1w, logic [1:0] p2w,
                                logic [1:0] rw, logic [1:0] mw);
        vec_t v;
        v.rst = r;  v.start = s; v.h1 = h1; v.h2 = h2;
        v.ph = ph;  v.rr = rr;   v.fz = fz;
        v.p1w = p1w; v.p2w = p2w; v.rw = rw; v.mw = mw;
        return v;
    endfunction

    // Drive one vector for one clock, then check outputs 1 time unit later.
    task automatic apply(input string tag, input int idx, input vec_t v);
        logic [14:0] act, exp;
        rst                = v.rst;
        bus.start          = v.start;
        bus.player1_health = v.h1;
        bus.player2_health = v.h2;
        @(posedge clk);
        #1;
        act = {bus.phase, bus.round_rst, bus.freeze, bus.p1_wins, bus.p2_wins,
               bus.round_winner, bus.match_winner};
        exp = {v.ph, v.rr, v.fz, v.p1w, v.p2w, v.rw, v.mw};
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s[%0d] ph/rr/fz/p1w/p2w/rw/mw got %0d/%b/%b/%0d/%0d/%b/%b expected %0d/%b/%b/%0d/%0d/%b/%b",
                     tag, idx,
                     act[14:12], act[11], act[10], act[9:8], act[7:6], act[5:4], act[3:0] >> 2 == 0 ? act[3:2] : act[3:2], 
                     exp[14:12], exp[11], exp[10], exp[9:8], exp[7:6], exp[5:4], exp[3:2]);
            $display("FAIL %s[%0d] match_winner got %b expected %b", tag, idx, act[1:0], exp[1:0]);
        end
    endtask

    // From CLEAR: three INTRO cycles then the edge into FIGHT.
    task automatic intro_fight(input string tag, input logic [1:0] p1w, input logic [1:0] p2w,
                               input logic [2:0] h1, input logic [2:0] h2);
        for (int i = 0; i < 3; i++) apply(tag, i, mk(0, 0, h1, h2, 3'd2, 0, 1, p1w, p2w, 2'b00, 2'b00));
        apply(tag, 3, mk(0, 0, h1, h2, 3'd3, 0, 0, p1w, p2w, 2'b00, 2'b00));
    endtask

    vec_t tbl[$];

    initial begin
        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.player1_health = 3'd3;
        bus.player2_health = 3'd3;

        //                 rst st h1 h2   ph rr fz p1 p2 rw     mw
        tbl.push_back(mk(1, 0, 3, 3,   0, 1, 1, 0, 0, 2'b00, 2'b00)); // reset
        tbl.push_back(mk(0, 0, 3, 3,   0, 1, 1, 0, 0, 2'b00, 2'b00)); // idle holds
        tbl.push_back(mk(0, 1, 3, 3,   1, 1, 1, 0, 0, 2'b00, 2'b00)); // start -> CLEAR
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00)); // INTRO x3
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   3, 0, 0, 0, 0, 2'b00, 2'b00)); // FIGHT
        tbl.push_back(mk(0, 0, 3, 3,   3, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 0,   4, 0, 1, 1, 0, 2'b01, 2'b00)); // P2 KO'd
        tbl.push_back(mk(0, 1, 3, 3,   4, 0, 1, 1, 0, 2'b01, 2'b00)); // start ignored in KO
        tbl.push_back(mk(0, 0, 3, 3,   1, 1, 1, 1, 0, 2'b01, 2'b00)); // CLEAR
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 1, 0, 2'b00, 2'b00)); // rw cleared
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 1, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 1, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   3, 0, 0, 1, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 4,   4, 0, 1, 2, 0, 2'b01, 2'b00)); // h2=4 wrap
        tbl.push_back(mk(0, 0, 3, 3,   4, 0, 1, 2, 0, 2'b01, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   5, 0, 1, 2, 0, 2'b01, 2'b01)); // match to P1
        tbl.push_back(mk(0, 0, 0, 0,   5, 0, 1, 2, 0, 2'b01, 2'b01)); // holds
        tbl.push_back(mk(0, 1, 3, 3,   1, 1, 1, 0, 0, 2'b01, 2'b00)); // restart
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   3, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 0, 0,   4, 0, 1, 0, 0, 2'b11, 2'b00)); // draw
        tbl.push_back(mk(0, 0, 3, 3,   4, 0, 1, 0, 0, 2'b11, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   1, 1, 1, 0, 0, 2'b11, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   3, 0, 0, 0, 0, 2'b00, 2'b00));
        tbl.push_back(mk(0, 0, 7, 3,   4, 0, 1, 0, 1, 2'b10, 2'b00)); // h1=7 wrap
        tbl.push_back(mk(0, 0, 3, 3,   4, 0, 1, 0, 1, 2'b10, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   1, 1, 1, 0, 1, 2'b10, 2'b00));
        tbl.push_back(mk(0, 0, 3, 3,   2, 0, 1, 0, 1, 2'b00, 2'b00));
        tbl.push_back(mk(1, 0, 3, 3,   0, 1, 1, 0, 0, 2'b00, 2'b00)); // rst in INTRO
        tbl.push_back(mk(0, 0, 3, 3,   0, 1, 1, 0, 0, 2'b00, 2'b00));

        foreach (tbl[i]) apply("tbl", i, tbl[i]);

        // Start held through FIGHT, KO coincident with start, reset in FIGHT.
        apply("seqA", 0, mk(0, 1, 3, 3, 1, 1, 1, 0, 0, 2'b00, 2'b00));
        intro_fight("seqA_r1", 0, 0, 3, 3);
        apply("seqA", 1, mk(0, 1, 3, 3, 3, 0, 0, 0, 0, 2'b00, 2'b00));
        apply("seqA", 2, mk(0, 1, 3, 3, 3, 0, 0, 0, 0, 2'b00, 2'b00));
        apply("seqA", 3, mk(0, 1, 3, 0, 4, 0, 1, 1, 0, 2'b01, 2'b00));
        apply("seqA", 4, mk(0, 1, 3, 3, 4, 0, 1, 1, 0, 2'b01, 2'b00));
        apply("seqA", 5, mk(0, 0, 3, 3, 1, 1, 1, 1, 0, 2'b01, 2'b00));
        intro_fight("seqA_r2", 1, 0, 3, 3);
        apply("seqA", 6, mk(1, 1, 0, 3, 0, 1, 1, 0, 0, 2'b00, 2'b00));

        // Reset in KO after a P2 round win.
        apply("seqB", 0, mk(0, 1, 3, 3, 1, 1, 1, 0, 0, 2'b00, 2'b00));
        intro_fight("seqB_r1", 0, 0, 3, 3);
        apply("seqB", 1, mk(0, 0, 0, 3, 4, 0, 1, 0, 1, 2'b10, 2'b00));
        apply("seqB", 2, mk(1, 1, 3, 3, 0, 1, 1, 0, 0, 2'b00, 2'b00));
        apply("seqB", 3, mk(0, 0, 3, 3, 0, 1, 1, 0, 0, 2'b00, 2'b00));

        // Depletion present from INTRO is ignored there, then caught on the
        // first FIGHT cycle.
        apply("seqC", 0, mk(0, 1, 3, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00));
        intro_fight("seqC_r1", 0, 0, 3, 0);
        apply("seqC", 1, mk(0, 0, 3, 0, 4, 0, 1, 1, 0, 2'b01, 2'b00));
        apply("seqC", 2, mk(1, 0, 3, 3, 0, 1, 1, 0, 0, 2'b00, 2'b00));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
